vga_tile_display: RTL and testbench



---
 rtl/vga_tile_pkg.sv | 37 +++
 rtl/vga_timing.sv | 70 +++++++
 rtl/vga_tile_display.sv | 172 +++++++++++++++++
 tb/tb_vga_tile_display.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_tile_pkg.sv
// Shared timing defaults and derived-geometry helpers for the tile display.
package vga_tile_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int cols(input int h_act, input int shift);
        return h_act >> shift;
    endfunction

    function automatic int rows(input int v_act, input int shift);
        return v_act >> shift;
    endfunction

    function automatic int tiles(input int h_act, input int v_act, input int shift);
        return (h_act >> shift) * (v_act >> shift);
    endfunction

    function automatic int cnt_w(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters with sync-window, active-video and first-pixel decode.
module vga_timing
    import vga_tile_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int XW       = cnt_w(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    parameter int YW       = cnt_w(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_pix_en,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_active,
    output logic          o_first
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int XW1     = XW + 1;
    localparam int YW1     = YW + 1;

    localparam logic [XW-1:0] X_LAST = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_TOTAL - 1);
    // One extra bit so a window edge equal to the total still fits.
    localparam logic [XW:0]   H_ACT  = XW1'(H_ACTIVE);
    localparam logic [XW:0]   HS_LO  = XW1'(H_ACTIVE + H_FP);
    localparam logic [XW:0]   HS_HI  = XW1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW:0]   V_ACT  = YW1'(V_ACTIVE);
    localparam logic [YW:0]   VS_LO  = YW1'(V_ACTIVE + V_FP);
    localparam logic [YW:0]   VS_HI  = YW1'(V_ACTIVE + V_FP + V_SYNC);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [XW:0]   w_xe;
    logic [YW:0]   w_ye;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_pix_en) begin
            if (r_x == X_LAST) begin
                r_x <= '0;
                r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign w_xe     = {1'b0, r_x};
    assign w_ye     = {1'b0, r_y};
    assign o_x      = r_x;
    assign o_y      = r_y;
    assign o_hsync  = (w_xe >= HS_LO) && (w_xe < HS_HI);
    assign o_vsync  = (w_ye >= VS_LO) && (w_ye < VS_HI);
    assign o_active = (w_xe < H_ACT) && (w_ye < V_ACT);
    assign o_first  = (r_x == '0) && (r_y == '0);

endmodule

// File: rtl/vga_tile_display.sv
// VGA scan-out of a tile framebuffer: write packer, tile RAM and 2-stage output pipeline.
module vga_tile_display
    import vga_tile_pkg::*;
#(
    parameter int H_ACTIVE      = DEF_H_ACTIVE,
    parameter int H_FP          = DEF_H_FP,
    parameter int H_SYNC        = DEF_H_SYNC,
    parameter int H_BP          = DEF_H_BP,
    parameter int V_ACTIVE      = DEF_V_ACTIVE,
    parameter int V_FP          = DEF_V_FP,
    parameter int V_SYNC        = DEF_V_SYNC,
    parameter int V_BP          = DEF_V_BP,
    parameter int SYNC_POL      = 0,
    parameter int TILE_SHIFT    = 4,
    parameter int COLOR_BITS    = 1,
    parameter int WR_BLANK_ONLY = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [7:0] wr_data,
    input  logic       wr_clear,
    output logic       r,
    output logic       g,
    output logic       b,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    localparam int   H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int   V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int   XW      = cnt_w(H_TOTAL);
    localparam int   YW      = cnt_w(V_TOTAL);
    localparam int   COLS    = cols(H_ACTIVE, TILE_SHIFT);
    localparam int   TILES   = tiles(H_ACTIVE, V_ACTIVE, TILE_SHIFT);
    localparam int   AW      = cnt_w(TILES);
    localparam int   PW      = cnt_w(TILES + 8);
    localparam bit   MONO    = (COLOR_BITS == 1);
    localparam int   STEP    = MONO ? 8 : 1;
    localparam int   RAM_W   = MONO ? 8 : 3;
    localparam int   RAM_D   = MONO ? (TILES + 7) / 8 : TILES;
    localparam int   RAW     = cnt_w(RAM_D);
    localparam logic SP      = (SYNC_POL != 0);
    localparam bit   BLANK_ONLY = (WR_BLANK_ONLY != 0);

    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic          w_hs, w_vs, w_active, w_first;
    logic [AW-1:0] w_tile;

    vga_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .XW(XW), .YW(YW)
    ) u_timing (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_pix_en (pix_en),
        .o_x      (w_x),
        .o_y      (w_y),
        .o_hsync  (w_hs),
        .o_vsync  (w_vs),
        .o_active (w_active),
        .o_first  (w_first)
    );

    // Blanking pixels read tile 0 so the RAM address never leaves range.
    assign w_tile = w_active
        ? AW'(32'(w_y >> TILE_SHIFT) * 32'(COLS) + 32'(w_x >> TILE_SHIFT))
        : '0;

    logic          r_s1_vld, r_s1_active, r_s1_hs, r_s1_vs, r_s1_first;
    logic [AW-1:0] r_s1_addr;
    logic          r_s2_active, r_s2_hs, r_s2_vs;
    logic          r_fs;
    logic          r_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld    <= 1'b0;
            r_s1_active <= 1'b0;
            r_s1_hs     <= 1'b0;
            r_s1_vs     <= 1'b0;
            r_s1_first  <= 1'b0;
            r_s1_addr   <= '0;
            r_s2_active <= 1'b0;
            r_s2_hs     <= 1'b0;
            r_s2_vs     <= 1'b0;
        end else if (pix_en) begin
            r_s1_vld    <= 1'b1;
            r_s1_active <= w_active;
            r_s1_hs     <= w_hs;
            r_s1_vs     <= w_vs;
            r_s1_first  <= w_first;
            r_s1_addr   <= w_tile;
            r_s2_active <= r_s1_vld && r_s1_active;
            r_s2_hs     <= r_s1_vld && r_s1_hs;
            r_s2_vs     <= r_s1_vld && r_s1_vs;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fs  <= 1'b0;
            r_run <= 1'b0;
        end else begin
            r_fs  <= pix_en && r_s1_vld && r_s1_first;
            r_run <= 1'b1;
        end
    end

    // Write side: mono packs 8 tiles per byte, so the pointer stays byte-aligned.
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    w_wr_base, w_wr_sum, w_wr_next;
    logic [RAW-1:0]   w_wr_addr, w_rd_addr;
    logic [RAM_W-1:0] w_wr_word;
    logic             w_wr_fire;

    assign wr_ready  = r_run && !(BLANK_ONLY && r_s1_active);
    assign w_wr_fire = wr_valid && wr_ready;
    assign w_wr_base = wr_clear ? '0 : r_wr_ptr;
    assign w_wr_sum  = w_wr_base + PW'(STEP);
    assign w_wr_next = (w_wr_sum >= PW'(TILES)) ? '0 : w_wr_sum;
    assign w_wr_addr = RAW'(MONO ? (w_wr_base >> 3) : w_wr_base);
    assign w_wr_word = RAM_W'(wr_data);
    assign w_rd_addr = RAW'(MONO ? (r_s1_addr >> 3) : r_s1_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_wr_ptr <= '0;
        else if (w_wr_fire)
            r_wr_ptr <= w_wr_next;
        else if (wr_clear)
            r_wr_ptr <= '0;
    end

    logic [RAM_W-1:0] r_mem [RAM_D];
    logic [RAM_W-1:0] r_rd;

    // Same-clock write/read of one word returns the old contents.
    always_ff @(posedge clk) begin
        if (w_wr_fire)
            r_mem[w_wr_addr] <= w_wr_word;
        if (pix_en)
            r_rd <= r_mem[w_rd_addr];
    end

    logic [2:0] w_color;

    if (MONO) begin : g_mono
        logic [2:0] r_bit;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_bit <= '0;
            else if (pix_en)
                r_bit <= r_s1_addr[2:0];
        end
        // Bit 7 of a byte maps to the lowest tile of its group.
        assign w_color = {3{r_rd[3'd7 - r_bit]}};
    end else begin : g_rgb
        assign w_color = r_rd[2:0];
    end

    assign {r, g, b}   = r_s2_active ? w_color : 3'b000;
    assign hsync       = r_s2_hs ? SP : ~SP;
    assign vsync       = r_s2_vs ? SP : ~SP;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_tile_display.sv
// Directed bench: a small 16x12 mode (24x16 totals, 4x4 tiles) in RGB and blank-only mono builds.
module tb_vga_tile_display;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_en = 1'b0;
    logic       wv_a = 1'b0, wc_a = 1'b0, wv_m = 1'b0, wc_m = 1'b0;
    logic [7:0] wd_a = 8'h00, wd_m = 8'h00;
    logic       wr_a, r_a, g_a, b_a, hs_a, vs_a, fs_a;
    logic       wr_m, r_m, g_m, b_m, hs_m, vs_m, fs_m;
    int         k;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // k = number of pix_en edges since reset release.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) k <= 0;
        else if (pix_en) k <= k + 1;

    vga_tile_display #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(0), .TILE_SHIFT(2), .COLOR_BITS(3), .WR_BLANK_ONLY(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .wr_valid(wv_a), .wr_ready(wr_a), .wr_data(wd_a), .wr_clear(wc_a),
        .r(r_a), .g(g_a), .b(b_a), .hsync(hs_a), .vsync(vs_a), .frame_start(fs_a)
    );

    vga_tile_display #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1), .TILE_SHIFT(2), .COLOR_BITS(1), .WR_BLANK_ONLY(1)
    ) dut_m (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .wr_valid(wv_m), .wr_ready(wr_m), .wr_data(wd_m), .wr_clear(wc_m),
        .r(r_m), .g(g_m), .b(b_m), .hsync(hs_m), .vsync(vs_m), .frame_start(fs_m)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    task automatic at(input int t);
        int n = 0;
        while (k < t && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (k >= t) else begin
            errors++;
            $error("FAIL wait_edge: got k=%0d expected %0d", k, t);
        end
    endtask

    task automatic put_a(input logic [7:0] d, input logic clr);
        int n = 0;
        wd_a = d; wc_a = clr; wv_a = 1'b1;
        @(negedge clk);
        while (!wr_a && n < 100) begin @(negedge clk); n++; end
        chk("put_a_ready", {7'b0, wr_a}, 8'h01);
        @(posedge clk); #1;
        wv_a = 1'b0; wc_a = 1'b0;
    endtask

    task automatic put_m(input logic [7:0] d);
        int n = 0;
        wd_m = d; wv_m = 1'b1;
        @(negedge clk);
        while (!wr_m && n < 100) begin @(negedge clk); n++; end
        chk("put_m_ready", {7'b0, wr_m}, 8'h01);
        @(posedge clk); #1;
        wv_m = 1'b0;
    endtask

    function automatic logic [7:0] rgb_a();
        return {5'b0, r_a, g_a, b_a};
    endfunction

    function automatic logic [7:0] rgb_m();
        return {5'b0, r_m, g_m, b_m};
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_rgb_a", rgb_a(), 8'h0);
        chk("rst_rgb_m", rgb_m(), 8'h0);
        chk("rst_hs_a", {7'b0, hs_a}, 8'h1);
        chk("rst_vs_a", {7'b0, vs_a}, 8'h1);
        chk("rst_hs_m", {7'b0, hs_m}, 8'h0);
        chk("rst_vs_m", {7'b0, vs_m}, 8'h0);
        chk("rst_fs_a", {7'b0, fs_a}, 8'h0);
        chk("rst_rdy_a", {7'b0, wr_a}, 8'h0);
        chk("rst_rdy_m", {7'b0, wr_m}, 8'h0);
        rst_n = 1'b1;

        // RGB: tiles k%8, then wrap to tiles 0..2, then clear-with-write and one more.
        for (int i = 0; i < 12; i++) put_a(8'(i % 8), 1'b0);
        put_a(8'h06, 1'b0);
        put_a(8'h07, 1'b0);
        put_a(8'h05, 1'b0);
        put_a(8'hF5, 1'b1);
        put_a(8'h02, 1'b0);
        // Mono: tile 0 white; tiles 8..11 = 1,0,1,0 with the tail bits dropped.
        put_m(8'h80);
        put_m(8'hAF);

        @(negedge clk);
        pix_en = 1'b1;
        at(1);
        chk("fs_e1", {7'b0, fs_a}, 8'h0);
        at(2);
        chk("fs_a_00", {7'b0, fs_a}, 8'h1);
        chk("fs_m_00", {7'b0, fs_m}, 8'h1);
        chk("rgb_a_00", rgb_a(), 8'h5);
        chk("rgb_m_00", rgb_m(), 8'h7);
        chk("hs_a_00", {7'b0, hs_a}, 8'h1);
        chk("hs_m_00", {7'b0, hs_m}, 8'h0);

        pix_en = 1'b0;
        @(negedge clk);
        chk("hold_fs", {7'b0, fs_a}, 8'h0);
        chk("hold_rgb_a", rgb_a(), 8'h5);
        chk("hold_rgb_m", rgb_m(), 8'h7);
        pix_en = 1'b1;

        at(3);
        chk("rgb_a_10", rgb_a(), 8'h5);
        at(6);
        chk("rgb_a_40", rgb_a(), 8'h2);
        chk("rgb_m_40", rgb_m(), 8'h0);
        chk("rdy_a_act", {7'b0, wr_a}, 8'h1);
        at(10);
        chk("rdy_m_act", {7'b0, wr_m}, 8'h0);
        at(12);
        chk("rgb_a_wrap_t2", rgb_a(), 8'h5);
        at(17);
        chk("rgb_a_t3_x15", rgb_a(), 8'h3);
        at(18);
        chk("rgb_a_x16", rgb_a(), 8'h0);
        at(19);
        chk("hs_a_x17", {7'b0, hs_a}, 8'h1);
        at(20);
        chk("rdy_m_blank", {7'b0, wr_m}, 8'h1);
        chk("hs_a_x18", {7'b0, hs_a}, 8'h0);
        chk("hs_m_x18", {7'b0, hs_m}, 8'h1);
        at(22);
        chk("hs_a_x20", {7'b0, hs_a}, 8'h0);
        at(23);
        chk("hs_a_x21", {7'b0, hs_a}, 8'h1);
        at(98);
        chk("rgb_a_t4", rgb_a(), 8'h4);
        chk("rgb_m_t4", rgb_m(), 8'h0);
        at(202);
        chk("rgb_a_t10", rgb_a(), 8'h2);
        chk("rgb_m_t10", rgb_m(), 8'h7);
        at(278);
        chk("rgb_a_t11", rgb_a(), 8'h3);
        chk("rgb_m_t11", rgb_m(), 8'h0);
        at(290);
        chk("rgb_a_y12", rgb_a(), 8'h0);
        chk("vs_a_y12", {7'b0, vs_a}, 8'h1);
        at(314);
        chk("vs_a_y13", {7'b0, vs_a}, 8'h0);
        chk("vs_m_y13", {7'b0, vs_m}, 8'h1);
        at(361);
        chk("vs_a_y14", {7'b0, vs_a}, 8'h0);
        at(362);
        chk("vs_a_y15", {7'b0, vs_a}, 8'h1);
        at(385);
        chk("fs_a_last", {7'b0, fs_a}, 8'h0);
        at(386);
        chk("fs_a_f2", {7'b0, fs_a}, 8'h1);
        chk("rgb_a_f2", rgb_a(), 8'h5);

        // Blank-only write issued during active video waits for blanking.
        at(388);
        chk("rdy_m_f2_act", {7'b0, wr_m}, 8'h0);
        put_m(8'h00);
        at(404);
        chk("rdy_m_f2_blank", {7'b0, wr_m}, 8'h1);
        at(770);
        chk("fs_m_f3", {7'b0, fs_m}, 8'h1);
        chk("rgb_m_f3_00", rgb_m(), 8'h0);
        chk("rgb_a_f3_00", rgb_a(), 8'h5);

        at(970);
        chk("rgb_a_pre_rst", rgb_a(), 8'h2);
        chk("rgb_m_pre_rst", rgb_m(), 8'h7);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_rgb_a", rgb_a(), 8'h0);
        chk("mrst_rgb_m", rgb_m(), 8'h0);
        chk("mrst_hs_a", {7'b0, hs_a}, 8'h1);
        chk("mrst_hs_m", {7'b0, hs_m}, 8'h0);
        chk("mrst_vs_m", {7'b0, vs_m}, 8'h0);
        chk("mrst_rdy_a", {7'b0, wr_a}, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        at(1);
        chk("rel_fs_e1", {7'b0, fs_a}, 8'h0);
        at(2);
        chk("rel_fs_a", {7'b0, fs_a}, 8'h1);
        chk("rel_fs_m", {7'b0, fs_m}, 8'h1);
        chk("rel_rgb_a", rgb_a(), 8'h5);
        chk("rel_rgb_m", rgb_m(), 8'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
